// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer driving an external N-bit up/down counter through repeated passes.
// Optional pause input enabled by defining SWEEP_PAUSE_EN.
module updown_sweep_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned R = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
`ifdef SWEEP_PAUSE_EN
  input  logic         pause,
`endif
  input  logic [N-1:0] cfg_start,
  input  logic [N-1:0] cfg_end,
  input  logic         cfg_up,
  input  logic [R-1:0] cfg_reps,
  input  logic         cfg_bounce,
  input  logic [N-1:0] cnt_q,
  output logic         cnt_en_b,
  output logic         cnt_load_b,
  output logic         cnt_up,
  output logic [N-1:0] cnt_load_in,
  output logic         busy,
  output logic         done,
  output logic [R-1:0] pass_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   start_q, start_d;
  logic [N-1:0]   end_q, end_d;
  logic           up_q, up_d;
  logic [R-1:0]   reps_q, reps_d;
  logic           bounce_q, bounce_d;
  logic [R-1:0]   pass_q, pass_d;
  logic           end_hit;
  logic           pause_act;

`ifdef SWEEP_PAUSE_EN
  assign pause_act = pause;
`else
  assign pause_act = 1'b0;
`endif

  assign end_hit = (cnt_q == end_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      start_q  <= '0;
      end_q    <= '0;
      up_q     <= 1'b0;
      reps_q   <= '0;
      bounce_q <= 1'b0;
      pass_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      end_q    <= end_d;
      up_q     <= up_d;
      reps_q   <= reps_d;
      bounce_q <= bounce_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    up_d       = up_q;
    reps_d     = reps_q;
    bounce_d   = bounce_q;
    pass_d     = pass_q;
    cnt_en_b   = 1'b1;
    cnt_load_b = 1'b1;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          start_d  = cfg_start;
          end_d    = cfg_end;
          up_d     = cfg_up;
          reps_d   = (cfg_reps == '0) ? {{(R-1){1'b0}}, 1'b1} : cfg_reps;
          bounce_d = cfg_bounce;
          pass_d   = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          cnt_en_b   = 1'b0;
          cnt_load_b = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (!pause_act) begin
          // Counter enable follows cnt_q so it holds exactly on the endpoint.
          cnt_en_b = end_hit;
          if (end_hit) begin
            pass_d = pass_q + 1'b1;
            if (pass_d == reps_q) begin
              state_d = StDone;
            end else if (bounce_q) begin
              start_d = end_q;
              end_d   = start_q;
              up_d    = ~up_q;
            end else begin
              state_d = StLoad;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cnt_up      = up_q;
  assign cnt_load_in = start_q;
  assign busy        = (state_q == StLoad) || (state_q == StRun);
  assign done        = (state_q == StDone);
  assign pass_cnt    = pass_q;

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Sequencer that drives one N-bit up/down counter instance through programmed sweeps.
- Each pass loads a start value, counts toward an end value in a chosen direction, and repeats for a programmed number of passes.
- Optional bounce mode reverses direction on each pass.
- Sits between the register/config logic and the counter; drives the counter's active-low enable and load pins and watches its q.

Parameters:
N, 4, counter width (must match the driven counter)
R, 4, width of repetition count and pass counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE
stop  in  1  synchronous abort
cfg_start  in  N  start value of first pass
cfg_end  in  N  end value of first pass
cfg_up  in  1  direction of first pass (1 = up)
cfg_reps  in  R  number of passes; 0 treated as 1
cfg_bounce  in  1  1 = alternate direction/endpoints each pass, no reload
cnt_q  in  N  counter's current value
cnt_en_b  out  1  counter enable, active-low
cnt_load_b  out  1  counter load, active-low
cnt_up  out  1  counter direction
cnt_load_in  out  N  counter load value
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse at normal completion
pass_cnt  out  R  completed passes in current/last sweep

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; cnt_en_b=1, cnt_load_b=1, cnt_up=0, cnt_load_in=0.
  - busy=0, done=0, pass_cnt=0.
  - Internal regs cleared. Counter q is undefined until the next LOAD.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - Counter held (en_b=1).
  - start=1 and stop=0: latch cfg_* into internal regs (start_r, end_r, up_r, reps_r with 0->1, bounce_r); clear pass_cnt; go to LOAD.
  - cfg_* changes after latch have no effect until the next start.
- LOAD:
  - Exactly one cycle: cnt_en_b=0, cnt_load_b=0, cnt_load_in=start_r.
  - Next state RUN; counter holds start_r in the first RUN cycle.
- RUN:
  - cnt_load_b=1, cnt_up=up_r.
  - cnt_en_b = (cnt_q == end_r), combinational on cnt_q. The counter steps every cycle until it reaches end_r, then holds.
  - Cycle where cnt_q == end_r (end-detect): pass_cnt increments at the clock edge.
    - If pass_cnt+1 == reps_r: go to DONE.
    - Else if bounce_r: swap start_r/end_r, invert up_r, stay in RUN (no reload).
    - Else: go to LOAD.
- DONE: one cycle, done=1, busy=0; then IDLE. pass_cnt holds its final value until the next start.
- Pass length:
  - Distance is modulo 2^N in the active direction. Up with end < start wraps through all-ones to 0.
  - d steps take d+1 RUN cycles.
  - start==end gives a zero-step pass: end-detect in the first RUN cycle.
- Single pass, start sampled at edge E0:
  - LOAD in cycle 1, RUN in cycles 2..d+2, DONE in cycle d+3.
- stop:
  - In LOAD or RUN: next state IDLE, cnt_en_b=1 that same cycle, no done pulse, pass_cnt frozen.
  - In IDLE: stop beats a simultaneous start; start is ignored.
  - In DONE: no effect.
- start outside IDLE is ignored.
- Reset during LOAD or RUN: immediate return to IDLE values; counter stops stepping asynchronously with rst_n.

Optional Feature:
- Macro SWEEP_PAUSE_EN.
- With the macro: adds input port pause (1 bit).
  - In RUN, pause=1 forces cnt_en_b=1 and suppresses end-detect and state change for that cycle. busy stays 1.
  - pause is ignored in IDLE, LOAD and DONE.
  - stop overrides pause.
- Without the macro: no pause port; RUN behaves as described above.

Test Plan:
- Reset mid-RUN: assert rst_n=0 -> cnt_en_b=1, cnt_load_b=1, busy=0, pass_cnt=0, state IDLE, all asynchronously.
- Single pass, start=3, end=6, up, reps=1:
  - LOAD drives cnt_load_in=3.
  - cnt_q reads 3,4,5,6 over RUN.
  - done pulses in cycle 6 after start is sampled; pass_cnt=1.
- Wrap, N=4, start=14, end=1, up, reps=1 -> cnt_q sequence 14,15,0,1; single done; pass_cnt=1.
- Bounce, start=2, end=4, up, reps=3, bounce=1:
  - cnt_q sequence 2,3,4,3,2,3,4.
  - No LOAD between passes; cnt_up toggles at each endpoint.
  - done after third pass; pass_cnt=3.
- Reload and reps=0 corner:
  - reps=2, bounce=0, start=5, end=3, down -> 5,4,3, one LOAD cycle, 5,4,3; pass_cnt=2.
  - reps=0 -> runs one pass.
- Stop during RUN of a 10-step pass at cnt_q=7 -> counter holds 7, busy=0 next cycle, no done. start+stop together in IDLE -> stays IDLE.
- (SWEEP_PAUSE_EN) pause held 3 cycles mid-RUN -> cnt_q frozen for 3 cycles; total sweep extends by exactly 3 cycles.
